seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the operand and result width in bits (N >= 2).
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  operand/opcode presented.
REQ-006 in_ready  output  1  block can accept a command.
REQ-007 s  input  3  opcode.
REQ-008 acc_sel  input  1  replaces operand a with the last result register.
REQ-009 a, b  input  N each  operands.
REQ-010 out_valid  output  1  result and flags valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 c  output  N  result.
REQ-013 flags  output  4  {neg, zero, carry, ovf}.

Function
REQ-014 A command SHALL be accepted on a rising edge when in_valid and in_ready are both 1; the inputs SHALL be captured on that edge.
REQ-015 Opcodes SHALL be 000 ADD, 001 SUB (a-b), 010 AND, 011 OR, 100 XOR, 101 SHL by 1, 110 SHR logical by 1, 111 MUL unsigned.
REQ-016 The FSM SHALL have three states: IDLE (in_ready=1), BUSY (MUL in progress), HOLD (out_valid=1).
REQ-017 Single-cycle opcodes SHALL go IDLE -> HOLD, so out_valid rises 1 cycle after acceptance.
REQ-018 MUL SHALL go IDLE -> BUSY for exactly N cycles of shift-add -> HOLD, so out_valid rises N+1 cycles after acceptance.
REQ-019 HOLD SHALL keep c and flags stable until out_ready=1, then return to IDLE on that edge.
REQ-020 in_ready SHALL be 0 in BUSY and HOLD, so there is no overlap or pipelining.
REQ-021 ADD/SUB results SHALL be modulo 2^N; carry = carry-out for ADD and borrow (a<b unsigned) for SUB; ovf = signed two's-complement overflow.
REQ-022 SHL carry SHALL be a[N-1]; SHR carry SHALL be a[0]; logic ops SHALL clear carry; ovf SHALL be 0 for every opcode except ADD and SUB.
REQ-023 MUL SHALL compute the 2N-bit product; c = low N bits; carry = 1 if the high N bits are nonzero; ovf = 0.
REQ-024 For all opcodes, zero = (c == 0) and neg = c[N-1].
REQ-025 The last-result register SHALL update to c on every entry into HOLD; with acc_sel=1 it SHALL be used as operand a.
REQ-026 In IDLE, out_valid SHALL be 0; c and flags SHALL retain their last values.

Reset
REQ-027 On rst=1 at a clock edge, the FSM SHALL return to IDLE, with out_valid=0, in_ready=1, c=0, flags=0, last-result=0, and the multiplier state cleared.
REQ-028 Reset SHALL abort any BUSY or HOLD operation with no result emitted.
REQ-029 Reset SHALL take priority over a simultaneous in_valid or out_ready.

Structure
REQ-030 Opcode localparams, the FSM state encoding and the flag bit indices SHALL live in a shared package, seq_alu_pkg.
REQ-031 The shift-add multiplier SHALL be a sub-module, shift_add_mul (parameter N, start/done, 2N-bit product), instantiated once.
REQ-032 All remaining logic (FSM, single-cycle datapath, flags) SHALL be in seq_alu.

Verification (N=4)
REQ-033 ADD a=1001, b=1010 -> c=0011, carry=1, ovf=1, zero=0, neg=0; out_valid rises 1 cycle after acceptance.
REQ-034 SUB a=0100, b=1000 -> c=1100, carry=1, ovf=1, neg=1.
REQ-035 MUL a=1110, b=0111 -> c=0010, carry=1 (product 0110_0010); out_valid rises exactly 5 cycles after acceptance; in_ready=0 throughout.
REQ-036 Backpressure: XOR a=0110, b=0011 with out_ready=0 for 3 cycles -> c=0101 held stable, in_ready=0; one cycle after out_ready=1, in_ready=1.
REQ-037 Accumulate: ADD a=0011, b=0000, then acc_sel=1 ADD b=0001 -> second c=0100; then SHR with acc_sel=1 -> c=0010, carry=0.
REQ-038 Reset: rst=1 in the 2nd BUSY cycle of MUL -> next cycle out_valid=0, in_ready=1, c=0000; no out_valid pulse follows.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states, flag bit positions.
package seq_alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Bit positions inside the 4-bit flags word {neg, zero, carry, ovf}.
    localparam int FLAG_NEG   = 3;
    localparam int FLAG_ZERO  = 2;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_OVF   = 0;

endpackage

// File: rtl/seq_alu_if.sv
// Command/result handshake bundle between a requester (master) and the ALU (slave).
interface seq_alu_if #(
    parameter int N = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   s;
    logic         acc_sel;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] c;
    logic [3:0]   flags;

    modport master (
        output in_valid, s, acc_sel, a, b, out_ready,
        input  in_ready, out_valid, c, flags
    );

    modport slave (
        input  in_valid, s, acc_sel, a, b, out_ready,
        output in_ready, out_valid, c, flags
    );
endinterface

// File: rtl/shift_add_mul.sv
// Unsigned N x N shift-add multiplier: one partial product per cycle, N cycles per product.
module shift_add_mul #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_start,
    input  logic [N-1:0]   i_a,
    input  logic [N-1:0]   i_b,
    output logic           o_done,
    output logic [2*N-1:0] o_product
);
    localparam int CW = $clog2(N + 1);

    logic [2*N-1:0] r_mcand;
    logic [N-1:0]   r_mplier;
    logic [2*N-1:0] r_prod;
    logic [CW-1:0]  r_cnt;
    logic [2*N-1:0] w_next_prod;

    assign w_next_prod = r_prod + (r_mplier[0] ? r_mcand : '0);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
        end else if (i_start) begin
            r_mcand  <= {{N{1'b0}}, i_a};
            r_mplier <= i_b;
            r_prod   <= '0;
            r_cnt    <= CW'(N);
        end else if (r_cnt != '0) begin
            r_prod   <= w_next_prod;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - CW'(1);
        end
    end

    // The final partial product is added on the same edge the consumer captures it.
    assign o_done    = (r_cnt == CW'(1));
    assign o_product = w_next_prod;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith ops plus a multi-cycle multiply, with result hold.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int N = 4
) (
    input logic     clk,
    input logic     rst,
    seq_alu_if.slave bus
);
    state_t         r_state;
    state_t         w_state_next;
    logic [N-1:0]   r_c;
    logic [N-1:0]   r_last;
    logic [3:0]     r_flags;

    logic           w_load;
    logic           w_mul_start;
    logic           w_mul_done;
    logic [2*N-1:0] w_mul_prod;

    logic [N-1:0]   w_op_a;
    logic [N:0]     w_sum;
    logic [N-1:0]   w_alu_c;
    logic           w_alu_carry;
    logic           w_alu_ovf;
    logic [N-1:0]   w_res_c;
    logic [3:0]     w_res_flags;

    assign w_op_a = bus.acc_sel ? r_last : bus.a;

    shift_add_mul #(.N(N)) u_mul (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_mul_start),
        .i_a       (w_op_a),
        .i_b       (bus.b),
        .o_done    (w_mul_done),
        .o_product (w_mul_prod)
    );

    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    always_comb begin
        w_sum       = '0;
        w_alu_c     = '0;
        w_alu_carry = 1'b0;
        w_alu_ovf   = 1'b0;
        case (bus.s)
            OP_ADD: begin
                w_sum       = {1'b0, w_op_a} + {1'b0, bus.b};
                w_alu_c     = w_sum[N-1:0];
                w_alu_carry = w_sum[N];
                w_alu_ovf   = (w_op_a[N-1] == bus.b[N-1]) && (w_alu_c[N-1] != w_op_a[N-1]);
            end
            OP_SUB: begin
                // The extra top bit of the difference is the unsigned borrow.
                w_sum       = {1'b0, w_op_a} - {1'b0, bus.b};
                w_alu_c     = w_sum[N-1:0];
                w_alu_carry = w_sum[N];
                w_alu_ovf   = (w_op_a[N-1] != bus.b[N-1]) && (w_alu_c[N-1] != w_op_a[N-1]);
            end
            OP_AND: w_alu_c = w_op_a & bus.b;
            OP_OR:  w_alu_c = w_op_a | bus.b;
            OP_XOR: w_alu_c = w_op_a ^ bus.b;
            OP_SHL: begin
                w_alu_c     = {w_op_a[N-2:0], 1'b0};
                w_alu_carry = w_op_a[N-1];
            end
            OP_SHR: begin
                w_alu_c     = {1'b0, w_op_a[N-1:1]};
                w_alu_carry = w_op_a[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        w_res_flags = '0;
        if (r_state == ST_BUSY) begin
            w_res_c                 = w_mul_prod[N-1:0];
            w_res_flags[FLAG_CARRY] = |w_mul_prod[2*N-1:N];
        end else begin
            w_res_c                 = w_alu_c;
            w_res_flags[FLAG_CARRY] = w_alu_carry;
            w_res_flags[FLAG_OVF]   = w_alu_ovf;
        end
        w_res_flags[FLAG_NEG]  = w_res_c[N-1];
        w_res_flags[FLAG_ZERO] = (w_res_c == '0);
    end

    always_comb begin
        w_state_next  = r_state;
        w_load        = 1'b0;
        w_mul_start   = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    if (bus.s == OP_MUL) begin
                        w_mul_start  = 1'b1;
                        w_state_next = ST_BUSY;
                    end else begin
                        w_load       = 1'b1;
                        w_state_next = ST_HOLD;
                    end
                end
            end
            ST_BUSY: begin
                if (w_mul_done) begin
                    w_load       = 1'b1;
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_c     <= '0;
            r_flags <= '0;
            r_last  <= '0;
        end else if (w_load) begin
            r_c     <= w_res_c;
            r_flags <= w_res_flags;
            r_last  <= w_res_c;
        end
    end

    assign bus.c     = r_c;
    assign bus.flags = r_flags;

endmodule

// File: tb/tb_seq_alu.sv
// Randomised and directed bench for seq_alu against an arithmetic reference model.
module tb_seq_alu;
    import seq_alu_pkg::*;

    localparam int N = 4;
    localparam int M = 2 ** N;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [N-1:0] m_last;
    logic [N-1:0] got_c;
    logic [3:0]   got_f;

    seq_alu_if #(.N(N)) bus ();

    seq_alu #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns {c, neg, zero, carry, ovf} from plain integer arithmetic.
    function automatic logic [N+3:0] model(input logic [2:0] op, input int ua, input int ub);
        int r, cy, ov, sa, sb, sr;
        logic [N-1:0] rc;
        sa = (ua >= M / 2) ? ua - M : ua;
        sb = (ub >= M / 2) ? ub - M : ub;
        cy = 0;
        ov = 0;
        case (op)
            OP_ADD: begin
                r  = ua + ub;
                cy = (r >= M) ? 1 : 0;
                sr = sa + sb;
                ov = (sr > M / 2 - 1 || sr < -M / 2) ? 1 : 0;
                r  = r % M;
            end
            OP_SUB: begin
                r  = (ua - ub + M) % M;
                cy = (ua < ub) ? 1 : 0;
                sr = sa - sb;
                ov = (sr > M / 2 - 1 || sr < -M / 2) ? 1 : 0;
            end
            OP_AND: r = ua & ub;
            OP_OR:  r = ua | ub;
            OP_XOR: r = ua ^ ub;
            OP_SHL: begin
                r  = (ua * 2) % M;
                cy = (ua >= M / 2) ? 1 : 0;
            end
            OP_SHR: begin
                r  = ua / 2;
                cy = ua % 2;
            end
            default: begin
                r  = ua * ub;
                cy = (r >= M) ? 1 : 0;
                r  = r % M;
            end
        endcase
        rc = r[N-1:0];
        return {rc, (r >= M / 2) ? 1'b1 : 1'b0, (r == 0) ? 1'b1 : 1'b0, cy[0], ov[0]};
    endfunction

    task automatic run_cmd(input string tag, input logic [2:0] op, input logic acc,
                           input logic [N-1:0] a, input logic [N-1:0] b, input int hold,
                           output logic [N-1:0] oc, output logic [3:0] of);
        logic [N+3:0] exp;
        int           lat;
        logic         rdy_seen;
        @(negedge clk);
        check({tag, "_ready"}, bus.in_ready, 1);
        bus.in_valid  = 1'b1;
        bus.s         = op;
        bus.acc_sel   = acc;
        bus.a         = a;
        bus.b         = b;
        bus.out_ready = 1'b0;
        exp = model(op, acc ? m_last : a, b);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat      = 1;
        rdy_seen = 1'b0;
        while (!bus.out_valid && lat < 40) begin
            if (bus.in_ready) rdy_seen = 1'b1;
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, (op == OP_MUL) ? N + 1 : 1);
        check({tag, "_busy_ready"}, rdy_seen, 0);
        check({tag, "_c"}, bus.c, exp[N+3:4]);
        check({tag, "_flags"}, bus.flags, exp[3:0]);
        oc = bus.c;
        of = bus.flags;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold"}, {bus.out_valid, bus.in_ready, bus.c, bus.flags},
                  {1'b1, 1'b0, oc, of});
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_release"}, {bus.out_valid, bus.in_ready}, 2'b01);
        m_last = exp[N+3:4];
    endtask

    initial begin
        logic bad;
        bus.in_valid  = 1'b0;
        bus.s         = '0;
        bus.acc_sel   = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        m_last        = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", {bus.out_valid, bus.in_ready, bus.c, bus.flags}, {1'b0, 1'b1, 4'h0, 4'h0});
        rst = 1'b0;

        run_cmd("add", OP_ADD, 1'b0, 4'b1001, 4'b1010, 0, got_c, got_f);
        check("add_spec", {got_c, got_f}, {4'b0011, 4'b0011});
        run_cmd("sub", OP_SUB, 1'b0, 4'b0100, 4'b1000, 0, got_c, got_f);
        check("sub_spec", {got_c, got_f}, {4'b1100, 4'b1011});
        run_cmd("mul", OP_MUL, 1'b0, 4'b1110, 4'b0111, 0, got_c, got_f);
        check("mul_spec", {got_c, got_f}, {4'b0010, 4'b0010});
        run_cmd("xor_bp", OP_XOR, 1'b0, 4'b0110, 4'b0011, 3, got_c, got_f);
        check("xor_spec", got_c, 4'b0101);
        run_cmd("acc0", OP_ADD, 1'b0, 4'b0011, 4'b0000, 0, got_c, got_f);
        run_cmd("acc1", OP_ADD, 1'b1, 4'b1111, 4'b0001, 0, got_c, got_f);
        check("acc1_spec", got_c, 4'b0100);
        run_cmd("acc_shr", OP_SHR, 1'b1, 4'b1111, 4'b0000, 0, got_c, got_f);
        check("acc_shr_spec", {got_c, got_f[FLAG_CARRY]}, {4'b0010, 1'b0});
        run_cmd("shl", OP_SHL, 1'b0, 4'b1000, 4'b0000, 1, got_c, got_f);

        // Reset sampled on the edge that ends the second BUSY cycle of a multiply.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.s        = OP_MUL;
        bus.acc_sel  = 1'b0;
        bus.a        = 4'b1110;
        bus.b        = 4'b0111;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("rst_busy_ready", bus.in_ready, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_abort", {bus.out_valid, bus.in_ready, bus.c, bus.flags}, {1'b0, 1'b1, 4'h0, 4'h0});
        m_last = '0;
        bad    = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.out_valid) bad = 1'b1;
        end
        check("rst_no_pulse", bad, 0);
        run_cmd("rst_last", OP_ADD, 1'b1, 4'b1111, 4'b0101, 0, got_c, got_f);
        check("rst_last_spec", got_c, 4'b0101);

        for (int k = 0; k < 40; k++) begin
            run_cmd("rand", 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    N'($urandom_range(0, M - 1)), N'($urandom_range(0, M - 1)),
                    int'($urandom_range(0, 2)), got_c, got_f);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
